seg_frame_capture: RTL and testbench
====================================

// Module: seg_frame_capture
// PURPOSE
// Receive-side monitor for the multiplexed 4-digit 7-segment bus (active-low anodes and cathodes).
// It watches the anode rotation 1110->1101->1011->0111 and samples the cathodes once per digit dwell.
// It decodes each glyph back to a hex nibble and publishes a complete 16-bit frame with a valid pulse.
// It is used in self-check benches and on-board loopback to confirm what the display is showing.
// PARAMETERS
// SETTLE_CYCLES   4      synced clk cycles an anode pattern must hold before cathodes are sampled (>=1)
// TIMEOUT_CYCLES  1024   cycles with no anode change before stall is flagged (>SETTLE_CYCLES)
// TIMER_W         16     width of dwell timer; must hold TIMEOUT_CYCLES
// PORTS
// clk          in   1   system clock
// rst          in   1   reset, asynchronous, active-high
// an_n         in   4   anode select, active-low; an_n[k]=0 selects digit k
// seg_n        in   7   cathodes, active-low, {g,f,e,d,c,b,a}
// dp_n         in   1   decimal point cathode, active-low
// value        out  16  last complete frame, digit k in value[4k+3:4k]
// dp_out       out  4   last frame decimal points, active-high, bit k = digit k
// glyph_err    out  4   last frame: bit k=1 if digit k pattern was not a legal hex glyph
// frame_valid  out  1   1-cycle pulse; value/dp_out/glyph_err updated on the same cycle
// sel_err      out  1   1-cycle pulse on illegal anode pattern or out-of-order digit
// stall        out  1   level; high while the anode pattern has been static >= TIMEOUT_CYCLES
// BEHAVIOUR
// - Reset: all outputs 0; state HUNT; sync flops an=4'b1111, seg=7'h7F, dp=1; timer 0; shadow regs 0.
// - All inputs pass through a 2-flop synchronizer; "an_q" below means the synced anode value.
// - Dwell timer: clears to 0 on any an_q change, else increments and saturates at TIMEOUT_CYCLES.
// - Sample point: the single cycle where timer==SETTLE_CYCLES-1 and an_q is one-hot-low; exactly one sample per dwell.
// - an_q==4'b1111 (blanking): no sample, no error, state unchanged.
// - an_q with >=2 zeros: sel_err pulse once when the timer reaches SETTLE_CYCLES-1; state -> HUNT.
// - FSM HUNT: on a sample of digit 0, store it in shadow slot 0, set exp=1, -> CAPTURE; other digits ignored.
// - FSM CAPTURE: on a sample of digit exp, store it in shadow slot exp.
//   - If exp==3: next cycle pulse frame_valid, load outputs from shadow, -> HUNT.
//   - Otherwise: exp<=exp+1.
// - CAPTURE, sample of digit != exp: sel_err pulse, partial frame dropped.
//   - If that digit is 0, it restarts the frame (slot 0 stored, exp=1).
//   - Otherwise -> HUNT.
// - Decode (active-high gfedcba = ~seg_n):
//   - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//   - Any other pattern -> nibble 0, glyph_err bit set for that slot.
//   - dp_out bit = ~dp_n at the sample.
// - Stall: timer reaching TIMEOUT_CYCLES sets stall=1 and forces HUNT, discarding the partial frame.
//   - stall clears on the cycle an_q next changes.
//   - Simultaneous timeout and change: the change wins, so stall does not assert.
// - Latency from a raw pin change to the sample: 2 (sync) + SETTLE_CYCLES cycles.
//   - frame_valid follows the digit-3 sample by 1 cycle.
// - Async rst mid-frame: immediate return to reset values; the partial frame is never published.
// - value/dp_out/glyph_err hold between frames; they change only with frame_valid.
// TESTING
// - Rotate an_n 1110,1101,1011,0111 with 8-cycle dwell, glyphs 1,2,3,4 (~06,~5B,~4F,~66), dp_n=0 on digit 2
//   -> frame_valid once per rotation, value=16'h4321, dp_out=4'b0100, glyph_err=0.
// - Same rotation, digit 1 cathodes=~7'h49
//   -> value=16'h4301, glyph_err=4'b0010, sel_err stays 0.
// - Dwell of SETTLE_CYCLES+1 (minimum) vs SETTLE_CYCLES-1 raw cycles
//   -> frames published in the first case; no sample and no frame_valid in the second.
// - Inject an_n=1100 for 8 cycles mid-frame, then resume rotation from 1110
//   -> one sel_err pulse; next full rotation gives value=16'h4321.
// - Skip digit 2 (1110,1101,0111,...) -> sel_err on the 0111 sample, no frame until an in-order rotation.
// - Hold an_n=1101 for 1100 cycles -> stall=1 after 1024+2 cycles, clears 3 cycles after an_n changes;
//   - assert rst while capturing digit 2 -> all outputs 0 and the next frame_valid only after a full rotation.

Source files
------------

// File: rtl/seg_frame_capture_if.sv
// Seven-segment display bus as seen by a receive-side monitor, plus the
// decoded frame results that the monitor publishes.
interface seg_frame_capture_if;
    // display side: active-low anode selects and cathodes {g,f,e,d,c,b,a}
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    // decoded frame results
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  glyph_err;
    logic        frame_valid;
    logic        sel_err;
    logic        stall;

    // master drives the display pins and observes the results
    modport master (
        output an_n, seg_n, dp_n,
        input  value, dp_out, glyph_err, frame_valid, sel_err, stall
    );

    // slave is the capture block: watches the pins, produces the results
    modport slave (
        input  an_n, seg_n, dp_n,
        output value, dp_out, glyph_err, frame_valid, sel_err, stall
    );
endinterface

// File: rtl/seg_frame_capture.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus.
// Follows the anode rotation, samples each digit once per dwell, decodes the
// glyph back to a hex nibble and publishes a full 16-bit frame with a pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | waiting for a digit-0 sample to start a new frame
//   CAPTURE | collecting digits in order; exp holds the next digit index
module seg_frame_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_W        = 16
) (
    input logic                clk,
    input logic                rst,
    seg_frame_capture_if.slave bus
);

    localparam logic [TIMER_W-1:0] SAMPLE_AT = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // synchronizer stages
    logic [3:0]         an_s1;
    logic [3:0]         an_q;
    logic [6:0]         seg_s1;
    logic [6:0]         seg_q;
    logic               dp_s1;
    logic               dp_q;

    // dwell tracking
    logic [3:0]         an_prev;
    logic               an_chg;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               timeout_hit;
    logic               stall_r;

    // anode classification at the sample point
    logic               at_sample;
    logic               onehot;
    logic               multi_sel;
    logic               sample;
    logic               bad_sel;
    logic [1:0]         dig;

    // glyph decode of the synced cathodes
    logic [3:0]         nib;
    logic               nib_err;

    // FSM
    state_t             state;
    state_t             state_nxt;
    logic [1:0]         exp_dig;
    logic [1:0]         exp_nxt;
    logic               store;
    logic               publish;
    logic               sel_err_nxt;

    // frame under construction and published results
    logic [15:0]        sh_val;
    logic [3:0]         sh_dp;
    logic [3:0]         sh_err;
    logic [15:0]        value_r;
    logic [3:0]         dp_out_r;
    logic [3:0]         glyph_err_r;
    logic               frame_valid_r;
    logic               sel_err_r;

    // Active-high gfedcba -> {err, nibble}; anything off the hex font is an error.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // Two-flop synchronizers; idle values match a blanked, dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1  <= 4'b1111;
            an_q   <= 4'b1111;
            seg_s1 <= 7'h7F;
            seg_q  <= 7'h7F;
            dp_s1  <= 1'b1;
            dp_q   <= 1'b1;
        end else begin
            an_s1  <= bus.an_n;
            an_q   <= an_s1;
            seg_s1 <= bus.seg_n;
            seg_q  <= seg_s1;
            dp_s1  <= bus.dp_n;
            dp_q   <= dp_s1;
        end
    end

    // Dwell timer: restarts on every anode change and parks at the timeout.
    always_comb begin
        an_chg      = (an_q != an_prev);
        timer_nxt   = timer;
        if (an_chg) begin
            timer_nxt = '0;
        end else if (timer != TIMEOUT_T) begin
            timer_nxt = timer + TIMER_W'(1);
        end
        timeout_hit = !an_chg && (timer_nxt == TIMEOUT_T);
    end

    // Timer and stall level; an anode change always beats a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_prev <= 4'b1111;
            timer   <= '0;
            stall_r <= 1'b0;
        end else begin
            an_prev <= an_q;
            timer   <= timer_nxt;
            if (an_chg) begin
                stall_r <= 1'b0;
            end else if (timeout_hit) begin
                stall_r <= 1'b1;
            end
        end
    end

    // Classify the anode pattern and decode the cathodes at the sample point.
    // The change cycle is excluded because the timer still holds the old dwell.
    always_comb begin
        logic [4:0] dec;
        at_sample = !an_chg && (timer == SAMPLE_AT);
        onehot    = $onehot(~an_q);
        multi_sel = !onehot && (an_q != 4'b1111);
        sample    = at_sample && onehot;
        bad_sel   = at_sample && multi_sel;
        case (an_q)
            4'b1110: dig = 2'd0;
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: dig = 2'd0;
        endcase
        dec     = decode_glyph(~seg_q);
        nib     = dec[3:0];
        nib_err = dec[4];
    end

    // Frame sequencing: next state, expected digit, shadow store and pulses.
    always_comb begin
        state_nxt   = state;
        exp_nxt     = exp_dig;
        store       = 1'b0;
        publish     = 1'b0;
        sel_err_nxt = 1'b0;
        if (timeout_hit) begin
            state_nxt = HUNT;
            exp_nxt   = 2'd0;
        end else if (bad_sel) begin
            sel_err_nxt = 1'b1;
            state_nxt   = HUNT;
            exp_nxt     = 2'd0;
        end else if (sample) begin
            case (state)
                HUNT: begin
                    if (dig == 2'd0) begin
                        store     = 1'b1;
                        exp_nxt   = 2'd1;
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (dig == exp_dig) begin
                        store = 1'b1;
                        if (exp_dig == 2'd3) begin
                            publish   = 1'b1;
                            state_nxt = HUNT;
                            exp_nxt   = 2'd0;
                        end else begin
                            exp_nxt = exp_dig + 2'd1;
                        end
                    end else begin
                        sel_err_nxt = 1'b1;
                        if (dig == 2'd0) begin
                            store   = 1'b1;
                            exp_nxt = 2'd1;
                        end else begin
                            state_nxt = HUNT;
                            exp_nxt   = 2'd0;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    exp_nxt   = 2'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            exp_dig <= 2'd0;
        end else begin
            state   <= state_nxt;
            exp_dig <= exp_nxt;
        end
    end

    // Shadow slots collect the frame; digit 3 bypasses straight into the outputs
    // so the frame appears on the cycle right after the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val        <= '0;
            sh_dp         <= '0;
            sh_err        <= '0;
            value_r       <= '0;
            dp_out_r      <= '0;
            glyph_err_r   <= '0;
            frame_valid_r <= 1'b0;
            sel_err_r     <= 1'b0;
        end else begin
            if (store) begin
                sh_val[{dig, 2'b00} +: 4] <= nib;
                sh_dp[dig]                <= ~dp_q;
                sh_err[dig]               <= nib_err;
            end
            if (publish) begin
                value_r     <= {nib, sh_val[11:0]};
                dp_out_r    <= {~dp_q, sh_dp[2:0]};
                glyph_err_r <= {nib_err, sh_err[2:0]};
            end
            frame_valid_r <= publish;
            sel_err_r     <= sel_err_nxt;
        end
    end

    assign bus.value       = value_r;
    assign bus.dp_out      = dp_out_r;
    assign bus.glyph_err   = glyph_err_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.sel_err     = sel_err_r;
    assign bus.stall       = stall_r;

endmodule

// File: tb/tb_seg_frame_capture.sv
// Bench for seg_frame_capture: table of full rotations, hand-written corner
// sequences, then random dwell streams checked against a dwell-level model.
module tb_seg_frame_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_frame_capture_if bus();

    seg_frame_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TIMER_W       (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e;
    } frame_t;

    typedef struct {
        logic [6:0]  g0, g1, g2, g3;
        logic [3:0]  dp;
        logic [15:0] ev;
        logic [3:0]  edp;
        logic [3:0]  eerr;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     fv_cnt   = 0;
    int     se_cnt   = 0;
    frame_t got_q[$];

    // reference model state
    logic [6:0] glyph_lut[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         run = 0;
    logic [3:0] m_nib[4];
    logic       m_dp[4];
    logic       m_err[4];
    frame_t     exp_q[$];
    int         m_sel = 0;

    vec_t vecs[7];

    // pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt++;
            got_q.push_back({bus.value, bus.dp_out, bus.glyph_err});
        end
        if (bus.sel_err) se_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] g, input logic dp, input int len);
        bus.an_n  = an;
        bus.seg_n = ~g;
        bus.dp_n  = ~dp;
        repeat (len) @(negedge clk);
    endtask

    task automatic blank();
        drive(4'b1111, 7'h00, 1'b0, 8);
    endtask

    task automatic rotate(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                          input logic [6:0] g3, input logic [3:0] dp, input int len);
        drive(4'b1110, g0, dp[0], len);
        drive(4'b1101, g1, dp[1], len);
        drive(4'b1011, g2, dp[2], len);
        drive(4'b0111, g3, dp[3], len);
        blank();
    endtask

    // Model one anode dwell: only dwells long enough to settle are seen at all.
    task automatic model_dwell(input logic [3:0] an, input logic [6:0] g, input logic dp, input int len);
        int         zeros;
        int         d;
        logic [3:0] nb;
        logic       er;
        zeros = 0;
        d     = 0;
        for (int k = 0; k < 4; k++) begin
            if (!an[k]) begin
                zeros++;
                d = k;
            end
        end
        if (an == 4'b1111 || len < SETTLE + 1) return;
        if (zeros >= 2) begin
            m_sel++;
            run = 0;
            return;
        end
        nb = 4'h0;
        er = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (glyph_lut[n] == g) begin
                nb = 4'(n);
                er = 1'b0;
            end
        end
        if (d == run) begin
            m_nib[d] = nb;
            m_dp[d]  = dp;
            m_err[d] = er;
            run++;
            if (run == 4) begin
                exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0],
                                 m_dp[3], m_dp[2], m_dp[1], m_dp[0],
                                 m_err[3], m_err[2], m_err[1], m_err[0]});
                run = 0;
            end
        end else if (run != 0) begin
            m_sel++;
            if (d == 0) begin
                m_nib[0] = nb;
                m_dp[0]  = dp;
                m_err[0] = er;
                run      = 1;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic random_batch(input int n);
        int         f0, s0, next_dig, len, r;
        logic [3:0] an, last;
        logic [6:0] g;
        logic       dp;
        exp_q.delete();
        got_q.delete();
        f0       = fv_cnt;
        s0       = se_cnt;
        m_sel    = 0;
        run      = 0;
        next_dig = 0;
        last     = 4'b1111;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                an       = ~(4'b0001 << next_dig);
                next_dig = (next_dig + 1) % 4;
            end else if (r < 8) begin
                an = 4'($urandom_range(0, 15));
            end else begin
                an = 4'b1111;
            end
            if (an == last) an = (last != 4'b1111) ? 4'b1111 : 4'b1110;
            len = int'($urandom_range(2, 10));
            if ($urandom_range(0, 4) != 0) g = glyph_lut[$urandom_range(0, 15)];
            else                           g = 7'($urandom_range(0, 127));
            dp = 1'($urandom_range(0, 1));
            drive(an, g, dp, len);
            model_dwell(an, g, dp, len);
            last = an;
        end
        // an illegal selection parks both sides in the hunting state
        an = (last != 4'b1100) ? 4'b1100 : 4'b0000;
        drive(an, 7'h00, 1'b0, 8);
        model_dwell(an, 7'h00, 1'b0, 8);
        blank();
        chk("rand_frame_count", 32'(fv_cnt - f0), 32'(exp_q.size()));
        chk("rand_sel_err_count", 32'(se_cnt - s0), 32'(m_sel));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("rand_value", 32'(got_q[i].v), 32'(exp_q[i].v));
            chk("rand_dp_out", 32'(got_q[i].d), 32'(exp_q[i].d));
            chk("rand_glyph_err", 32'(got_q[i].e), 32'(exp_q[i].e));
        end
    endtask

    initial begin
        int f0, s0, first, clr;

        vecs[0] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100, 16'h4321, 4'b0100, 4'b0000};
        vecs[1] = '{7'h06, 7'h49, 7'h4F, 7'h66, 4'b0100, 16'h4301, 4'b0100, 4'b0010};
        vecs[2] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 4'b0000, 16'h3210, 4'b0000, 4'b0000};
        vecs[3] = '{7'h66, 7'h6D, 7'h7D, 7'h07, 4'b1001, 16'h7654, 4'b1001, 4'b0000};
        vecs[4] = '{7'h7F, 7'h6F, 7'h77, 7'h7C, 4'b0000, 16'hBA98, 4'b0000, 4'b0000};
        vecs[5] = '{7'h39, 7'h5E, 7'h79, 7'h71, 4'b1111, 16'hFEDC, 4'b1111, 4'b0000};
        vecs[6] = '{7'h00, 7'h7E, 7'h3F, 7'h01, 4'b0000, 16'h0000, 4'b0000, 4'b1011};

        bus.an_n  = 4'b1111;
        bus.seg_n = 7'h7F;
        bus.dp_n  = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_value", 32'(bus.value), 32'h0);
        chk("reset_dp_out", 32'(bus.dp_out), 32'h0);
        chk("reset_glyph_err", 32'(bus.glyph_err), 32'h0);
        chk("reset_frame_valid", 32'(bus.frame_valid), 32'h0);
        chk("reset_sel_err", 32'(bus.sel_err), 32'h0);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // full rotations from the vector table
        for (int i = 0; i < 7; i++) begin
            f0 = fv_cnt;
            s0 = se_cnt;
            rotate(vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3, vecs[i].dp, 8);
            chk("vec_frame_count", 32'(fv_cnt - f0), 32'd1);
            chk("vec_value", 32'(bus.value), 32'(vecs[i].ev));
            chk("vec_dp_out", 32'(bus.dp_out), 32'(vecs[i].edp));
            chk("vec_glyph_err", 32'(bus.glyph_err), 32'(vecs[i].eerr));
            chk("vec_sel_err", 32'(se_cnt - s0), 32'd0);
        end

        // minimum dwell publishes; shorter dwells never sample
        f0 = fv_cnt;
        rotate(7'h3F, 7'h06, 7'h5B, 7'h4F, 4'b0000, SETTLE + 1);
        chk("min_dwell_frames", 32'(fv_cnt - f0), 32'd1);
        chk("min_dwell_value", 32'(bus.value), 32'h3210);
        f0 = fv_cnt;
        s0 = se_cnt;
        rotate(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b1111, SETTLE);
        rotate(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b1111, SETTLE - 1);
        chk("short_dwell_frames", 32'(fv_cnt - f0), 32'd0);
        chk("short_dwell_value_held", 32'(bus.value), 32'h3210);
        chk("short_dwell_dp_held", 32'(bus.dp_out), 32'h0);
        chk("short_dwell_sel_err", 32'(se_cnt - s0), 32'd0);

        // illegal two-digit select mid-frame, then a clean rotation
        f0 = fv_cnt;
        s0 = se_cnt;
        drive(4'b1110, 7'h06, 1'b0, 8);
        drive(4'b1101, 7'h5B, 1'b0, 8);
        drive(4'b1100, 7'h4F, 1'b0, 8);
        rotate(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100, 8);
        chk("inject_sel_err", 32'(se_cnt - s0), 32'd1);
        chk("inject_frames", 32'(fv_cnt - f0), 32'd1);
        chk("inject_value", 32'(bus.value), 32'h4321);

        // skipped digit 2
        f0 = fv_cnt;
        s0 = se_cnt;
        drive(4'b1110, 7'h3F, 1'b0, 8);
        drive(4'b1101, 7'h3F, 1'b0, 8);
        drive(4'b0111, 7'h3F, 1'b0, 8);
        blank();
        chk("skip_sel_err", 32'(se_cnt - s0), 32'd1);
        chk("skip_no_frame", 32'(fv_cnt - f0), 32'd0);
        chk("skip_value_held", 32'(bus.value), 32'h4321);
        rotate(7'h3F, 7'h06, 7'h5B, 7'h4F, 4'b0000, 8);
        chk("skip_recover_frames", 32'(fv_cnt - f0), 32'd1);
        chk("skip_recover_value", 32'(bus.value), 32'h3210);

        // stall on a static anode, then release; partial frame must be dropped
        f0 = fv_cnt;
        s0 = se_cnt;
        drive(4'b1110, 7'h06, 1'b0, 8);
        bus.an_n  = 4'b1101;
        bus.seg_n = ~7'h5B;
        bus.dp_n  = 1'b1;
        first = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (bus.stall && first == 0) first = k;
        end
        chk_range("stall_rise_cycle", first, TIMEOUT + 2, TIMEOUT + 4);
        chk("stall_level_held", 32'(bus.stall), 32'd1);
        bus.an_n  = 4'b1011;
        bus.seg_n = ~7'h4F;
        clr = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!bus.stall && clr == 0) clr = k;
        end
        chk_range("stall_clear_cycle", clr, 2, 4);
        drive(4'b0111, 7'h66, 1'b0, 8);
        blank();
        chk("stall_partial_dropped", 32'(fv_cnt - f0), 32'd0);
        chk("stall_sel_err", 32'(se_cnt - s0), 32'd0);

        // asynchronous reset while digit 2 is on the bus
        rotate(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100, 8);
        f0 = fv_cnt;
        drive(4'b1110, 7'h06, 1'b0, 8);
        drive(4'b1101, 7'h5B, 1'b0, 8);
        drive(4'b1011, 7'h4F, 1'b1, 4);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_value", 32'(bus.value), 32'h0);
        chk("rst_mid_dp_out", 32'(bus.dp_out), 32'h0);
        chk("rst_mid_glyph_err", 32'(bus.glyph_err), 32'h0);
        chk("rst_mid_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1011, 7'h4F, 1'b1, 4);
        drive(4'b0111, 7'h66, 1'b0, 8);
        blank();
        chk("rst_partial_not_published", 32'(fv_cnt - f0), 32'd0);
        rotate(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100, 8);
        chk("rst_recover_frames", 32'(fv_cnt - f0), 32'd1);
        chk("rst_recover_value", 32'(bus.value), 32'h4321);
        chk("rst_recover_dp_out", 32'(bus.dp_out), 32'h4);

        // random dwell streams against the model
        for (int b = 0; b < 4; b++) random_batch(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
